// File: rtl/msf_encoder.sv
// msf_encoder: MSF 60 kHz time-signal carrier on/off keying generator.
// Latency: carrier_o/second_o/slot_o/minute_o registered, updated on the edge that enters each slot.
// Backpressure: none; free-running while en_i=1, idle (carrier on) while en_i=0.
//
// Ports:
//   clk_i, rst_i     clock and synchronous active-high reset
//   en_i             run enable; low abandons the frame and holds the block idle
//   year_i..minute_i BCD time fields for the minute starting at the next second 0
//   bst_i, bst_warn_i summer-time flags, captured with the time fields
//   dut1_i           (only with MSF_ENCODER_DUT1_EN) DUT1 sign/magnitude, 0.1 s units
//   carrier_o        1 = carrier on, 0 = carrier off
//   second_o,slot_o  current position in the frame (0-59, 0-9)
//   minute_o         one-cycle pulse on the first cycle of second 0
//
// Optional feature macro: MSF_ENCODER_DUT1_EN (adds dut1_i and DUT1 coding in seconds 1-16).

module msf_encoder #(
  parameter int SLOT_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] year_i,
  input  logic [4:0] month_i,
  input  logic [5:0] day_i,
  input  logic [2:0] dow_i,
  input  logic [5:0] hour_i,
  input  logic [6:0] minute_i,
  input  logic       bst_i,
  input  logic       bst_warn_i,
`ifdef MSF_ENCODER_DUT1_EN
  input  logic [4:0] dut1_i,
`endif
  output logic       carrier_o,
  output logic [5:0] second_o,
  output logic [3:0] slot_o,
  output logic       minute_o
);

  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // ---------------------------------------------------------------------------
  // Frame position and control registers
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [3:0]      slot_q, slot_d;
  logic [5:0]      sec_q, sec_d;
  logic            carrier_q, carrier_d;
  logic            minute_q, minute_d;
  logic            capture;

  // ---------------------------------------------------------------------------
  // Shadow copies of the time fields, frozen for a whole frame
  // ---------------------------------------------------------------------------
  logic [7:0]      year_q;
  logic [4:0]      month_q;
  logic [5:0]      day_q;
  logic [2:0]      dow_q;
  logic [5:0]      hour_q;
  logic [6:0]      minute_sh_q;
  logic            bst_q;
  logic            bst_warn_q;
`ifdef MSF_ENCODER_DUT1_EN
  logic [4:0]      dut1_q;
  logic [3:0]      dut1_mag;
`endif

  // Per-second A and B bits, indexed directly by second number. Kept 64 wide
  // so a 6-bit second indexes it without a range hole; bits 60-63 stay zero.
  logic [63:0]     a_vec;
  logic [63:0]     b_vec;
  logic            a_bit;
  logic            b_bit;

  // ---------------------------------------------------------------------------
  // Next-state logic: idle/run FSM plus cycle/slot/second counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    slot_d   = slot_q;
    sec_d    = sec_q;
    minute_d = 1'b0;
    capture  = 1'b0;

    if (!en_i) begin
      // Enable low abandons any frame in progress straight away.
      state_d = ST_IDLE;
      cyc_d   = '0;
      slot_d  = 4'd0;
      sec_d   = 6'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // The starting edge is already cycle 0 of second 0.
          state_d  = ST_RUN;
          cyc_d    = '0;
          slot_d   = 4'd0;
          sec_d    = 6'd0;
          capture  = 1'b1;
          minute_d = 1'b1;
        end
        ST_RUN: begin
          if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (slot_q == 4'd9) begin
              slot_d = 4'd0;
              if (sec_q == 6'd59) begin
                sec_d    = 6'd0;
                capture  = 1'b1;
                minute_d = 1'b1;
              end else begin
                sec_d = sec_q + 6'd1;
              end
            end else begin
              slot_d = slot_q + 4'd1;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // A-bit map: BCD fields sent MSB first, fixed 01111110 at seconds 52-59.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_vec = '0;
    for (int i = 0; i < 8; i++) a_vec[24 - i] = year_q[i];
    for (int i = 0; i < 5; i++) a_vec[29 - i] = month_q[i];
    for (int i = 0; i < 6; i++) a_vec[35 - i] = day_q[i];
    for (int i = 0; i < 3; i++) a_vec[38 - i] = dow_q[i];
    for (int i = 0; i < 6; i++) a_vec[44 - i] = hour_q[i];
    for (int i = 0; i < 7; i++) a_vec[51 - i] = minute_sh_q[i];
    a_vec[58:53] = 6'b111111;
  end

  // ---------------------------------------------------------------------------
  // B-bit map: summer-time flags and odd parity over the A groups.
  // Reduction XNOR is 1 when the group holds an even count of ones, which is
  // exactly the B value needed to make group+B odd.
  // ---------------------------------------------------------------------------
`ifdef MSF_ENCODER_DUT1_EN
  assign dut1_mag = (dut1_q[3:0] > 4'd8) ? 4'd8 : dut1_q[3:0];
`endif

  always_comb begin
    b_vec     = '0;
    b_vec[53] = bst_warn_q;
    b_vec[54] = ~^year_q;
    b_vec[55] = ~^{month_q, day_q};
    b_vec[56] = ~^dow_q;
    b_vec[57] = ~^{hour_q, minute_sh_q};
    b_vec[58] = bst_q;
`ifdef MSF_ENCODER_DUT1_EN
    // Positive DUT1 marks seconds 1..m, negative marks seconds 9..8+m.
    for (int s = 1; s <= 16; s++) begin
      if (!dut1_q[4]) begin
        b_vec[s] = (s <= int'(dut1_mag));
      end else begin
        b_vec[s] = (s >= 9) && (s <= 8 + int'(dut1_mag));
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Carrier for the slot being entered. Second 0 never depends on the shadow
  // registers, so a capture on the same edge cannot race the lookup.
  // ---------------------------------------------------------------------------
  assign a_bit = a_vec[sec_d];
  assign b_bit = b_vec[sec_d];

  always_comb begin
    carrier_d = 1'b1;
    if (state_d == ST_RUN) begin
      if (sec_d == 6'd0) begin
        carrier_d = (slot_d >= 4'd5);
      end else begin
        unique case (slot_d)
          4'd0:    carrier_d = 1'b0;
          4'd1:    carrier_d = ~a_bit;
          4'd2:    carrier_d = ~b_bit;
          default: carrier_d = 1'b1;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      slot_q    <= 4'd0;
      sec_q     <= 6'd0;
      carrier_q <= 1'b1;
      minute_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      slot_q    <= slot_d;
      sec_q     <= sec_d;
      carrier_q <= carrier_d;
      minute_q  <= minute_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      year_q      <= '0;
      month_q     <= '0;
      day_q       <= '0;
      dow_q       <= '0;
      hour_q      <= '0;
      minute_sh_q <= '0;
      bst_q       <= 1'b0;
      bst_warn_q  <= 1'b0;
`ifdef MSF_ENCODER_DUT1_EN
      dut1_q      <= '0;
`endif
    end else if (capture) begin
      year_q      <= year_i;
      month_q     <= month_i;
      day_q       <= day_i;
      dow_q       <= dow_i;
      hour_q      <= hour_i;
      minute_sh_q <= minute_i;
      bst_q       <= bst_i;
      bst_warn_q  <= bst_warn_i;
`ifdef MSF_ENCODER_DUT1_EN
      dut1_q      <= dut1_i;
`endif
    end
  end

  assign carrier_o = carrier_q;
  assign second_o  = sec_q;
  assign slot_o    = slot_q;
  assign minute_o  = minute_q;

endmodule
